// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR random-word arbiter.
//   state_e      : arbiter FSM states (IDLE, SHIFT, DONE)
//   TAP0..TAP3   : fixed feedback tap indices of the XNOR LFSR
//   DEFAULT_SEED : LFSR state after reset / lockup recovery
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int TAP0 = 7;
    localparam int TAP1 = 5;
    localparam int TAP2 = 4;
    localparam int TAP3 = 3;

    localparam logic [7:0] DEFAULT_SEED = 8'h5A;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci XNOR shift register, q <= {q[WIDTH-2:0], fb}.
//   clk      in  : clock, rising edge
//   reset    in  : synchronous active-high, loads SEED
//   step     in  : advance one position
//   load     in  : load load_val (wins over step)
//   load_val in  : replacement state
//   q        out : current state
//   fb       out : feedback bit that the next step shifts in
// Taps are fixed bit indices, so WIDTH must be at least 8.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             fb
);

    logic [WIDTH-1:0] reg_q, reg_d;

    // XNOR feedback: all-ones maps to itself.
    assign fb = ~(reg_q[TAP0] ^ reg_q[TAP1] ^ reg_q[TAP2] ^ reg_q[TAP3]);
    assign q  = reg_q;

    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = load_val;
        end else if (step) begin
            reg_d = {reg_q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q <= SEED;
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: rtl/lfsr_arb.sv
// lfsr_arb: two-requester arbiter that hands out NBITS-bit random words.
// A granted requester holds gnt for NBITS SHIFT cycles while the LFSR steps
// and each feedback bit enters the accumulator; the word is then presented
// with a one-cycle rnd_valid pulse in DONE.
//   clk        in  : clock, rising edge
//   reset      in  : synchronous active-high
//   req[1:0]   in  : level requests
//   seed_load  in  : load seed_val into the LFSR (honoured in IDLE only)
//   seed_val   in  : replacement LFSR state
//   gnt[1:0]   out : registered one-hot grant
//   rnd_valid  out : one-cycle pulse, rnd_data/rnd_id valid
//   rnd_data   out : delivered word, held until next rnd_valid
//   rnd_id     out : owner of rnd_data
//   busy       out : FSM not in IDLE
//   lfsr_q     out : LFSR state (debug)
// Optional feature: define LFSR_ARB_LOCKUP_GUARD_EN to reload SEED whenever
// the LFSR holds all-ones (that cycle does not count as a shift step).
module lfsr_arb
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               NBITS = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic [1:0]       gnt,
    output logic             rnd_valid,
    output logic [NBITS-1:0] rnd_data,
    output logic             rnd_id,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_q
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic [NBITS-1:0] rnd_data_q, rnd_data_d;
    logic             rnd_id_q, rnd_id_d;

    logic             lfsr_step, lfsr_load, lfsr_fb, lockup, winner;
    logic [WIDTH-1:0] lfsr_load_val;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_q),
        .fb       (lfsr_fb)
    );

`ifdef LFSR_ARB_LOCKUP_GUARD_EN
    assign lockup = &lfsr_q;
`else
    assign lockup = 1'b0;
`endif

    // Both requesting: pointer decides; otherwise the lone requester wins.
    assign winner = (req == 2'b11) ? ptr_q : req[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        gnt_d         = gnt_q;
        rnd_valid_d   = 1'b0;
        rnd_data_d    = rnd_data_q;
        rnd_id_d      = rnd_id_q;
        lfsr_step     = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_load_val = seed_val;

        case (state_q)
            IDLE: begin
                // Seed load defers any pending request by one cycle.
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (|req) begin
                    id_d    = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!lockup) begin
                    lfsr_step = 1'b1;
                    acc_d     = (acc_q << 1) | NBITS'(lfsr_fb);
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(NBITS - 1)) begin
                        state_d     = DONE;
                        gnt_d       = 2'b00;
                        rnd_valid_d = 1'b1;
                        rnd_data_d  = acc_d;
                        rnd_id_d    = id_q;
                    end
                end
            end
            DONE: begin
                ptr_d   = ~ptr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Lockup recovery replaces a step; an explicit seed load still wins.
        if (lockup && !lfsr_load) begin
            lfsr_load     = 1'b1;
            lfsr_load_val = SEED;
            lfsr_step     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            gnt_q       <= 2'b00;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            rnd_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_id    = rnd_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_arb.sv
// tb_lfsr_arb: directed checks of lfsr_arb (WIDTH=8, NBITS=4, SEED=8'h5A).
// A per-cycle vector table covers reset, single grants, seed load and its
// deferral; hand sequences cover round-robin, mid-shift reset and all-ones.
module tb_lfsr_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       seed_load;
    logic [7:0] seed_val;
    logic [1:0] gnt;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic       rnd_id;
    logic       busy;
    logic [7:0] lfsr_q;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_arb #(
        .WIDTH (8),
        .NBITS (4),
        .SEED  (8'h5A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_id    (rnd_id),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    typedef struct {
        logic       rst;
        logic [1:0] rq;
        logic       sl;
        logic [7:0] sv;
        logic [1:0] g;
        logic       v;
        logic [3:0] d;
        logic       i;
        logic       b;
        logic [7:0] l;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic rst, logic [1:0] rq, logic sl, logic [7:0] sv,
                                logic [1:0] g, logic v, logic [3:0] d, logic i,
                                logic b, logic [7:0] l);
        vec_t t;
        t.rst = rst; t.rq = rq; t.sl = sl; t.sv = sv;
        t.g = g; t.v = v; t.d = d; t.i = i; t.b = b; t.l = l;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_d[3];
        logic [1:0] exp_g[3];
        logic [16:0] act_v, exp_v;
        int c;
        bit seen;

        //          rst rq    sl sv     gnt   v  data  id b  lfsr
        tbl[0]  = mk(1, 2'b00, 0, 8'h00, 2'b00, 0, 4'h0, 0, 0, 8'h5A);
        tbl[1]  = mk(0, 2'b00, 0, 8'h00, 2'b00, 0, 4'h0, 0, 0, 8'h5A);
        tbl[2]  = mk(0, 2'b01, 0, 8'h00, 2'b01, 0, 4'h0, 0, 1, 8'h5A);
        tbl[3]  = mk(0, 2'b00, 1, 8'h00, 2'b01, 0, 4'h0, 0, 1, 8'hB5); // seed_load ignored
        tbl[4]  = mk(0, 2'b00, 0, 8'h00, 2'b01, 0, 4'h0, 0, 1, 8'h6A);
        tbl[5]  = mk(0, 2'b00, 0, 8'h00, 2'b01, 0, 4'h0, 0, 1, 8'hD5);
        tbl[6]  = mk(0, 2'b00, 0, 8'h00, 2'b00, 1, 4'hB, 0, 1, 8'hAB);
        tbl[7]  = mk(0, 2'b00, 0, 8'h00, 2'b00, 0, 4'hB, 0, 0, 8'hAB);
        tbl[8]  = mk(0, 2'b01, 1, 8'h3C, 2'b00, 0, 4'hB, 0, 0, 8'h3C); // load wins
        tbl[9]  = mk(0, 2'b01, 0, 8'h00, 2'b01, 0, 4'hB, 0, 1, 8'h3C);
        tbl[10] = mk(0, 2'b00, 0, 8'h00, 2'b01, 0, 4'hB, 0, 1, 8'h78);
        tbl[11] = mk(0, 2'b00, 0, 8'h00, 2'b01, 0, 4'hB, 0, 1, 8'hF0);
        tbl[12] = mk(0, 2'b00, 0, 8'h00, 2'b01, 0, 4'hB, 0, 1, 8'hE0);
        tbl[13] = mk(0, 2'b00, 0, 8'h00, 2'b00, 1, 4'h1, 0, 1, 8'hC1);
        tbl[14] = mk(0, 2'b00, 0, 8'h00, 2'b00, 0, 4'h1, 0, 0, 8'hC1);
        tbl[15] = mk(0, 2'b10, 0, 8'h00, 2'b10, 0, 4'h1, 0, 1, 8'hC1);
        tbl[16] = mk(0, 2'b00, 0, 8'h00, 2'b10, 0, 4'h1, 0, 1, 8'h82); // req dropped
        tbl[17] = mk(0, 2'b00, 0, 8'h00, 2'b10, 0, 4'h1, 0, 1, 8'h04);
        tbl[18] = mk(0, 2'b00, 0, 8'h00, 2'b10, 0, 4'h1, 0, 1, 8'h09);
        tbl[19] = mk(0, 2'b00, 0, 8'h00, 2'b00, 1, 4'h2, 1, 1, 8'h12);
        tbl[20] = mk(0, 2'b00, 0, 8'h00, 2'b00, 0, 4'h2, 1, 0, 8'h12);

        reset = 1'b1; req = 2'b00; seed_load = 1'b0; seed_val = 8'h00;

        // Output bundle {gnt, rnd_valid, rnd_data, rnd_id, busy, lfsr_q}.
        for (int k = 0; k < 21; k++) begin
            reset = tbl[k].rst; req = tbl[k].rq;
            seed_load = tbl[k].sl; seed_val = tbl[k].sv;
            tick();
            act_v = {gnt, rnd_valid, rnd_data, rnd_id, busy, lfsr_q};
            exp_v = {tbl[k].g, tbl[k].v, tbl[k].d, tbl[k].i, tbl[k].b, tbl[k].l};
            chk($sformatf("vec%0d", k), 32'(act_v), 32'(exp_v));
        end
        seed_load = 1'b0;

        // Round-robin with req=11 held, back-to-back.
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_d[0] = 4'hB;  exp_d[1] = 4'h1;  exp_d[2] = 4'h1;
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            c = 0;
            while (gnt == 2'b00 && c < 20) begin tick(); c++; end
            chk($sformatf("rr%0d_gap", k), 32'(c), (k == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_g[k]));
            c = 0;
            while (!rnd_valid && c < 20) begin tick(); c++; end
            chk($sformatf("rr%0d_lat", k), 32'(c), 32'd4);
            chk($sformatf("rr%0d_id", k), 32'(rnd_id), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_data", k), 32'(rnd_data), 32'(exp_d[k]));
        end
        req = 2'b00;

        // Reset in the third SHIFT cycle abandons the transaction.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b01; tick(); req = 2'b00;
        tick(); tick();
        chk("rst_pre_lfsr", 32'(lfsr_q), 32'h6A);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid", 32'({gnt, busy, rnd_valid, lfsr_q}), 32'({2'b00, 1'b0, 1'b0, 8'h5A}));
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen |= rnd_valid;
            tick();
        end
        chk("rst_no_valid", 32'(seen), 32'd0);

        // All-ones seed: recovered by the guard, otherwise a fixed point.
        reset = 1'b1; tick(); reset = 1'b0;
        seed_load = 1'b1; seed_val = 8'hFF; tick(); seed_load = 1'b0;
        chk("ff_loaded", 32'(lfsr_q), 32'hFF);
        req = 2'b01; tick(); req = 2'b00;
`ifdef LFSR_ARB_LOCKUP_GUARD_EN
        chk("ff_guard_lfsr", 32'(lfsr_q), 32'h5A);
`else
        chk("ff_stuck_lfsr", 32'(lfsr_q), 32'hFF);
`endif
        c = 0;
        while (!rnd_valid && c < 20) begin tick(); c++; end
        chk("ff_lat", 32'(c), 32'd4);
`ifdef LFSR_ARB_LOCKUP_GUARD_EN
        chk("ff_data", 32'({rnd_data, lfsr_q}), 32'({4'hB, 8'hAB}));
`else
        chk("ff_data", 32'({rnd_data, lfsr_q}), 32'({4'hF, 8'hFF}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
